// File: rtl/layer_dr_tx_pkg.sv
// rtl/layer_dr_tx_pkg.sv - shared constants for the dual-rail token tx bridge
package layer_dr_tx_pkg;

   localparam int BIT_DATA    = 8;
   localparam int MAX2D_KSIZE = 4;
   // Bits per channel slot of a window word
   localparam int KW          = BIT_DATA * MAX2D_KSIZE;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   localparam logic [1:0] DRTX_DRAIN  = 2'd0;
   localparam logic [1:0] DRTX_IDLE   = 2'd1;
   localparam logic [1:0] DRTX_DATA   = 2'd2;
   localparam logic [1:0] DRTX_SPACER = 2'd3;

endpackage

// File: rtl/layer_dr_tx_if.sv
// rtl/layer_dr_tx_if.sv - word input, dual-rail output and status bundle of the tx bridge
interface layer_dr_tx_if #(
   parameter int W        = 64,
   parameter int CNT_BITS = 16
);
   logic                in_valid;
   logic                in_ready;
   logic [W-1:0]        in_data;
   logic [W-1:0]        xt;
   logic [W-1:0]        xf;
   logic                ack_nxt;
   logic                busy;
   logic [CNT_BITS-1:0] token_count;
   logic                err_ack;

   // Producer plus async consumer side
   modport master (
      output in_valid, in_data, ack_nxt,
      input  in_ready, xt, xf, busy, token_count, err_ack
   );

   // Bridge side
   modport slave (
      input  in_valid, in_data, ack_nxt,
      output in_ready, xt, xf, busy, token_count, err_ack
   );
endinterface

// File: rtl/layer_dr_tx_sync_ff.sv
// rtl/layer_dr_tx_sync_ff.sv - generic async-reset multi-flop bit synchronizer
module layer_dr_tx_sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through STAGES flops before anyone looks at it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/layer_dr_tx.sv
// rtl/layer_dr_tx.sv - clocked words in, dual-rail four-phase RTZ tokens out
module layer_dr_tx
   import layer_dr_tx_pkg::*;
#(
   parameter int FILTER_IN   = 32,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_BITS    = 16
) (
   input logic          clk,
   input logic          reset,
   layer_dr_tx_if.slave bus
);
   localparam int W = KW * FILTER_IN;
   localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

   logic                ack_s;
   logic [1:0]          state_q, state_d;
   logic [W-1:0]        hold_q, hold_d;
   logic                hold_valid_q, hold_valid_d;
   logic [W-1:0]        xt_q, xt_d;
   logic [W-1:0]        xf_q, xf_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                in_ready;
   logic                accept;
   logic                unload;

   // The synchronizer comes out of reset showing ON, so a consumer that was
   // mid-cycle when we reset is always drained before the first new token.
   layer_dr_tx_sync_ff #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (ON)
   ) u_ack_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (bus.ack_nxt),
      .q_o   (ack_s)
   );

   assign in_ready = ~hold_valid_q & (state_q != DRTX_DRAIN);
   assign accept   = bus.in_valid & in_ready;

   // Handshake FSM, rail encoding, token counter, spurious-ack flag and hold register
   always_comb begin
      state_d      = state_q;
      xt_d         = xt_q;
      xf_d         = xf_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      unload       = 1'b0;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;

      case (state_q)
         DRTX_DRAIN: begin
            if (ack_s == OFF) begin
               state_d = DRTX_IDLE;
            end
         end
         DRTX_IDLE: begin
            // An ack with nothing outstanding is flagged; the token waits for the ack to clear
            if (ack_s == ON) begin
               err_d = 1'b1;
            end else if (hold_valid_q) begin
               xt_d    = hold_q;
               xf_d    = ~hold_q;
               unload  = 1'b1;
               state_d = DRTX_DATA;
            end
         end
         DRTX_DATA: begin
            if (ack_s == ON) begin
               xt_d    = '0;
               xf_d    = '0;
               state_d = DRTX_SPACER;
            end
         end
         DRTX_SPACER: begin
            if (ack_s == OFF) begin
               cnt_d = cnt_q + CNT_ONE;
               // Back-to-back: go straight to the next token without an idle cycle
               if (hold_valid_q) begin
                  xt_d    = hold_q;
                  xf_d    = ~hold_q;
                  unload  = 1'b1;
                  state_d = DRTX_DATA;
               end else begin
                  state_d = DRTX_IDLE;
               end
            end
         end
         default: state_d = DRTX_DRAIN;
      endcase

      // Unload first so an accept on the same edge lands in the freed slot
      if (unload) begin
         hold_valid_d = 1'b0;
      end
      if (accept) begin
         hold_d       = bus.in_data;
         hold_valid_d = 1'b1;
      end
   end

   // Register everything; reset drops the rails to spacer without waiting for a clock
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= DRTX_DRAIN;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         xt_q         <= '0;
         xf_q         <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         xt_q         <= xt_d;
         xf_q         <= xf_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.xt          = xt_q;
   assign bus.xf          = xf_q;
   assign bus.busy        = (state_q == DRTX_DATA) | (state_q == DRTX_SPACER) | hold_valid_q;
   assign bus.token_count = cnt_q;
   assign bus.err_ack     = err_q;
endmodule

// File: tb/tb_layer_dr_tx.sv
// tb/tb_layer_dr_tx.sv - self-checking bench for layer_dr_tx with a behavioural async consumer
module tb_layer_dr_tx;
   import layer_dr_tx_pkg::*;

   localparam int W        = 64;
   localparam int CNT_BITS = 4;
   localparam int CNT_MOD  = 1 << CNT_BITS;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   layer_dr_tx_if #(.W(W), .CNT_BITS(CNT_BITS)) bus ();

   layer_dr_tx #(
      .FILTER_IN   (2),
      .SYNC_STAGES (2),
      .CNT_BITS    (CNT_BITS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];
   int           model_cnt = 0;
   int           cyc       = 0;
   int           drop_cyc  = 0;
   int           gaps[$];
   bit           auto_ack  = 1'b0;
   logic         man_ack   = 1'b0;

   typedef struct {
      logic [W-1:0] din;
      logic [W-1:0] exp_xt;
      logic [W-1:0] exp_xf;
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit rails_full();
      return (bus.xt ^ bus.xf) == {W{1'b1}};
   endfunction

   function automatic bit rails_spacer();
      return (bus.xt == '0) && (bus.xf == '0);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural consumer: latch a complete token after 1..10 cycles, release after 1..10 more
   initial begin
      int cdelay;
      cdelay      = -1;
      bus.ack_nxt = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!auto_ack) begin
            bus.ack_nxt = man_ack;
            cdelay      = -1;
         end else if ((!bus.ack_nxt && rails_full()) || (bus.ack_nxt && rails_spacer())) begin
            if (cdelay < 0) cdelay = int'($urandom_range(1, 10));
            cdelay--;
            if (cdelay <= 0) begin
               cdelay = -1;
               if (!bus.ack_nxt) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL unexpected_token: got %h expected no token", bus.xt);
                  end else begin
                     chk("token_xt", bus.xt, exp_q[0]);
                     chk("token_xf", bus.xf, ~exp_q[0]);
                     void'(exp_q.pop_front());
                  end
                  bus.ack_nxt = 1'b1;
               end else begin
                  bus.ack_nxt = 1'b0;
                  drop_cyc    = cyc;
               end
            end
         end
      end
   end

   // Rail monitor: never both rails high, only full tokens or spacer, tokens held stable
   initial begin
      logic [W-1:0] prev_xt;
      bit           prev_full;
      bit           prev_sp;
      prev_xt   = '0;
      prev_full = 1'b0;
      prev_sp   = 1'b1;
      forever begin
         @(negedge clk);
         chk("no_both_rails", ~(bus.xt & bus.xf), {W{1'b1}});
         chk("rails_coherent", rails_full() || rails_spacer(), 1);
         if (prev_full && rails_full()) chk("rails_stable", bus.xt, prev_xt);
         if (prev_sp && rails_full()) gaps.push_back(cyc - drop_cyc);
         prev_full = rails_full();
         prev_sp   = rails_spacer();
         prev_xt   = bus.xt;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic push(input logic [W-1:0] d);
      int t;
      t = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         chk("push_accept", bus.in_ready, 1);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         exp_q.push_back(d);
      end
   endtask

   task automatic idle_in();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("wait_ready", bus.in_ready, 1);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || bus.ack_nxt || bus.busy) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_done", (exp_q.size() == 0) && !bus.busy, 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] d, a, b, c;

      vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
      vecs[1] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
      vecs[3] = '{64'hAAAA_5555_F0F0_0F0F, 64'hAAAA_5555_F0F0_0F0F, 64'h5555_AAAA_0F0F_F0F0};

      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (2) @(negedge clk);
      chk("rst_xt", bus.xt, 0);
      chk("rst_xf", bus.xf, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_count", bus.token_count, 0);
      chk("rst_err", bus.err_ack, 0);
      reset = 1'b0;

      // 1: single tokens with exact latencies
      for (int i = 0; i < 4; i++) begin
         wait_idle();
         push(vecs[i].din);
         idle_in();
         chk("t1_spacer_at_accept", bus.xt | bus.xf, 0);
         @(negedge clk);
         chk("t1_xt", bus.xt, vecs[i].exp_xt);
         chk("t1_xf", bus.xf, vecs[i].exp_xf);
         chk("t1_busy", bus.busy, 1);
         man_ack = 1'b1;
         repeat (3) begin
            @(negedge clk);
            chk("t1_token_held", bus.xt, vecs[i].exp_xt);
         end
         @(negedge clk);
         chk("t1_spacer_after_ack", bus.xt | bus.xf, 0);
         void'(exp_q.pop_front());
         man_ack = 1'b0;
         repeat (4) @(negedge clk);
         model_cnt++;
         chk("t1_count", bus.token_count, model_cnt % CNT_MOD);
         chk("t1_busy_done", bus.busy, 0);
      end

      // 2: back-to-back burst, order kept and no idle cycle between tokens
      wait_idle();
      auto_ack = 1'b1;
      gaps.delete();
      for (int i = 0; i < 8; i++) begin
         d = {$urandom, $urandom};
         push(d);
      end
      idle_in();
      wait_drain();
      model_cnt += 8;
      chk("t2_count", bus.token_count, model_cnt % CNT_MOD);
      chk("t2_token_starts", gaps.size(), 8);
      for (int i = 1; i < 8 && i < gaps.size(); i++) chk("t2_b2b_gap", gaps[i], 3);

      // 3: backpressure, consumer holds ack low for 50 cycles
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      push(a);
      push(b);
      @(negedge clk);
      bus.in_data = c;
      chk("t3_ready_after_2nd", bus.in_ready, 0);
      for (int i = 0; i < 50; i++) begin
         chk("t3_rails_stable", bus.xt, a);
         chk("t3_ready_low", bus.in_ready, 0);
         @(negedge clk);
      end
      chk("t3_third_not_taken", exp_q.size(), 2);
      auto_ack = 1'b1;
      push(c);
      idle_in();
      wait_drain();
      model_cnt += 3;
      chk("t3_count", bus.token_count, model_cnt % CNT_MOD);

      // 4: reset mid-DATA with the consumer still acking
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      wait_idle();
      d = {$urandom, $urandom};
      push(d);
      idle_in();
      @(negedge clk);
      chk("t4_token_out", bus.xt, d);
      man_ack = 1'b1;
      @(negedge clk);
      chk("t4_still_token", bus.xt, d);
      #2 reset = 1'b1;
      #1;
      chk("t4_xt_async", bus.xt, 0);
      chk("t4_xf_async", bus.xf, 0);
      chk("t4_count_rst", bus.token_count, 0);
      exp_q.delete();
      model_cnt = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_drain_ready", bus.in_ready, 0);
      end
      man_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t4_ready_sync", bus.in_ready, 0);
      end
      @(negedge clk);
      chk("t4_ready_up", bus.in_ready, 1);

      // 5: spurious ack in IDLE is sticky and loses nothing
      chk("t5_err_clear", bus.err_ack, 0);
      man_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t5_err_not_yet", bus.err_ack, 0);
      end
      @(negedge clk);
      chk("t5_err_set", bus.err_ack, 1);
      d = {$urandom, $urandom};
      push(d);
      idle_in();
      repeat (5) begin
         @(negedge clk);
         chk("t5_token_waits", bus.xt | bus.xf, 0);
      end
      auto_ack = 1'b1;
      wait_drain();
      model_cnt++;
      chk("t5_count", bus.token_count, model_cnt % CNT_MOD);
      chk("t5_err_sticky", bus.err_ack, 1);

      // 6: counter wraps after 17 tokens
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      chk("t6_err_cleared", bus.err_ack, 0);
      wait_idle();
      auto_ack = 1'b1;
      for (int i = 0; i < 17; i++) begin
         d = {$urandom, $urandom};
         push(d);
      end
      idle_in();
      wait_drain();
      model_cnt += 17;
      chk("t6_count_wrap", bus.token_count, model_cnt % CNT_MOD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
